axil_regbank: RTL

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_pkg.sv | 17 +
 rtl/axil_wr_strb_merge.sv | 18 +
 rtl/axil_regbank.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the width helper used to size
// the register-bank address fields.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axil_wr_strb_merge.sv
// Byte-lane merge of new write data into the old register value under WSTRB.
module axil_wr_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave exposing NUM_REGS word registers; registers flagged in
// RO_MASK read from ro_d instead of their own storage and reject writes.
module axil_regbank
  import axil_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  localparam int                 ADDR_W   = clog2(NUM_REGS) + clog2(DATA_W / 8)
) (
  input  logic                         ACLK,
  input  logic                         ARESET,

  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,

  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,

  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,

  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,

  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,

  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int             LANE_W    = clog2(DATA_W / 8);
  localparam int             IDX_W     = ADDR_W - LANE_W;
  localparam logic [IDX_W:0] REG_COUNT = NUM_REGS[IDX_W:0];

  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic                rvalid_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [IDX_W-1:0]    aw_idx;
  logic [IDX_W-1:0]    ar_idx;
  logic                aw_in_range;
  logic                ar_in_range;
  logic                aw_ro;
  logic                wr_ok;
  logic                wr_accept;
  logic                rd_accept;
  logic [NUM_REGS-1:0] aw_onehot;
  logic [DATA_W-1:0]   aw_old;
  logic [DATA_W-1:0]   aw_merged;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_bits;

  assign aw_idx      = S_AXI_AWADDR[ADDR_W-1:LANE_W];
  assign ar_idx      = S_AXI_ARADDR[ADDR_W-1:LANE_W];
  assign aw_in_range = {1'b0, aw_idx} < REG_COUNT;
  assign ar_in_range = {1'b0, ar_idx} < REG_COUNT;
  assign wr_ok       = aw_in_range && !aw_ro;

  // Address and data must both be present; a pending response blocks the next write.
  assign wr_accept     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !ARESET;
  assign rd_accept     = S_AXI_ARVALID && !rvalid_q && !ARESET;
  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign wr_pulse     = pulse_q;

  assign unused_bits = &{1'b0, S_AXI_AWADDR[LANE_W-1:0], S_AXI_ARADDR[LANE_W-1:0], ro_d};

  always_comb begin
    aw_old    = '0;
    aw_ro     = 1'b0;
    aw_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        aw_old       = regs[i];
        aw_ro        = RO_MASK[i];
        aw_onehot[i] = 1'b1;
      end
    end
  end

  // Out-of-range indices match no register and therefore read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs[i];
      end
    end
  end

  axil_wr_strb_merge #(
    .DATA_W(DATA_W)
  ) u_merge (
    .old_data(aw_old),
    .new_data(S_AXI_WDATA),
    .strb    (S_AXI_WSTRB),
    .merged  (aw_merged)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      pulse_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pulse_q <= '0;
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_accept) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          pulse_q <= aw_onehot;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_onehot[i]) regs[i] <= aw_merged;
          end
        end
      end
    end
  end

  // Read data is captured at acceptance, so a same-edge write is not seen.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (rd_accept) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_word;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
